// File: rtl/bram_portb_arbiter.sv
// Round-robin arbiter sharing BRAM port B between two req/gnt masters with bounded bursts.
// Optional MMIO_GUARD_EN blocks the 0x300-0x3FF I/O window and adds the io_violation output.
module bram_portb_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] addr_b,
    output logic [WIDTH-1:0] data_b,
    output logic             we_b,
    input  logic [WIDTH-1:0] q_b
`ifdef MMIO_GUARD_EN
    ,
    output logic             io_violation
`endif
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] BURST_TOP = 8'(MAX_BURST - 1);

    state_t     state, state_nx;
    logic       last, last_nx;
    logic [7:0] burst_cnt, burst_nx;
    logic       xfer;
    logic       sel_we;
    logic       rd_xfer;
    logic       blocked;

    always_comb begin
        state_nx = state;
        last_nx  = last;
        burst_nx = burst_cnt;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nx = last ? OWN0 : OWN1;
                else if (req0)
                    state_nx = OWN0;
                else if (req1)
                    state_nx = OWN1;
            end
            OWN0: begin
                if (!req0) begin
                    state_nx = req1 ? OWN1 : IDLE;
                    last_nx  = 1'b0;
                    burst_nx = '0;
                end else if (req1) begin
                    // Count only contested cycles; reaching the top hands over.
                    if (burst_cnt == BURST_TOP) begin
                        state_nx = OWN1;
                        last_nx  = 1'b0;
                        burst_nx = '0;
                    end else begin
                        burst_nx = burst_cnt + 8'd1;
                    end
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_nx = req0 ? OWN0 : IDLE;
                    last_nx  = 1'b1;
                    burst_nx = '0;
                end else if (req0) begin
                    if (burst_cnt == BURST_TOP) begin
                        state_nx = OWN0;
                        last_nx  = 1'b1;
                        burst_nx = '0;
                    end else begin
                        burst_nx = burst_cnt + 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        addr_b = '0;
        data_b = '0;
        sel_we = 1'b0;
        xfer   = 1'b0;
        case (state)
            OWN0: begin
                addr_b = addr0;
                data_b = wdata0;
                sel_we = we0;
                xfer   = req0;
            end
            OWN1: begin
                addr_b = addr1;
                data_b = wdata1;
                sel_we = we1;
                xfer   = req1;
            end
            default: ;
        endcase
    end

`ifdef MMIO_GUARD_EN
    assign blocked = xfer & addr_b[9] & addr_b[8];
`else
    assign blocked = 1'b0;
`endif

    // we_b derives from state so an async reset removes it without waiting for a clock.
    assign we_b    = xfer & sel_we & ~blocked;
    assign rd_xfer = xfer & ~sel_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            burst_cnt <= burst_nx;
            gnt0      <= (state_nx == OWN0);
            gnt1      <= (state_nx == OWN1);
            rvalid0   <= rd_xfer & (state == OWN0);
            rvalid1   <= rd_xfer & (state == OWN1);
            if (rd_xfer)
                rdata <= blocked ? '0 : q_b;
        end
    end

`ifdef MMIO_GUARD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            io_violation <= 1'b0;
        else
            io_violation <= blocked;
    end
`endif

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Self-checking bench for bram_portb_arbiter: behavioural grant/memory model plus directed scenarios.
// Exercises the MMIO_GUARD_EN window checks when that macro is defined.
module tb_bram_portb_arbiter;

    localparam int MAXB = 8;
`ifdef MMIO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, we_b;
    logic [15:0] rdata, addr_b, data_b;
    logic [15:0] q_b = '0;
`ifdef MMIO_GUARD_EN
    logic        io_violation;
`endif

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    bram_portb_arbiter #(.WIDTH(16), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
`ifdef MMIO_GUARD_EN
        , .io_violation(io_violation)
`endif
    );

    // BRAM port B, clocked on the falling edge.
    logic [15:0] bram [1024];
    always @(negedge clk) begin
        if (we_b) bram[addr_b[9:0]] <= data_b;
        q_b <= bram[addr_b[9:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner -1/0/1, contested-cycle streak, memory contents.
    int          m_owner  = -1;
    bit          m_last   = 1'b1;
    int          m_streak = 0;
    bit          m_rv0 = 0, m_rv1 = 0, m_io = 0;
    logic [15:0] m_rdata = '0;
    logic [15:0] ref_mem [1024];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i]    = 16'h1000 + 16'(i);
            ref_mem[i] = 16'h1000 + 16'(i);
        end
        for (int i = 0; i < 4; i++) begin
            bram[16 + i]    = 16'h00A0 + 16'(i);
            ref_mem[16 + i] = 16'h00A0 + 16'(i);
        end
    end

    always @(negedge clk) begin : cmp
        logic [15:0] ea, ed, a;
        logic        ew, ro, rx, w, blk;
        int          o;
        if (!reset) begin
            m_owner = -1; m_last = 1'b1; m_streak = 0;
            m_rv0 = 0; m_rv1 = 0; m_io = 0; m_rdata = '0;
            chk("rst_gnt", {gnt1, gnt0}, 2'b00);
            chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
            chk("rst_rdata", rdata, 16'h0);
            chk("rst_we_b", we_b, 1'b0);
        end else begin
            ea = '0; ed = '0; ew = 1'b0;
            if (m_owner == 0) begin
                ea = addr0; ed = wdata0; ew = we0 & req0 & ~(GUARD & addr0[9] & addr0[8]);
            end else if (m_owner == 1) begin
                ea = addr1; ed = wdata1; ew = we1 & req1 & ~(GUARD & addr1[9] & addr1[8]);
            end
            chk("gnt0", gnt0, m_owner == 0);
            chk("gnt1", gnt1, m_owner == 1);
            chk("rvalid0", rvalid0, m_rv0);
            chk("rvalid1", rvalid1, m_rv1);
            if (m_rv0 || m_rv1) chk("rdata", rdata, m_rdata);
            chk("addr_b", addr_b, ea);
            chk("data_b", data_b, ed);
            chk("we_b", we_b, ew);
`ifdef MMIO_GUARD_EN
            chk("io_violation", io_violation, m_io);
`endif
            // Effects of the cycle ending at the coming rising edge.
            m_rv0 = 0; m_rv1 = 0; m_io = 0;
            o = m_owner;
            if (o >= 0) begin
                ro = (o == 0) ? req0 : req1;
                rx = (o == 0) ? req1 : req0;
                a  = (o == 0) ? addr0 : addr1;
                w  = (o == 0) ? we0 : we1;
                if (ro) begin
                    blk  = GUARD & a[9] & a[8];
                    m_io = blk;
                    if (!w) begin
                        if (o == 0) m_rv0 = 1; else m_rv1 = 1;
                        m_rdata = blk ? 16'h0 : ref_mem[a[9:0]];
                    end else if (!blk) begin
                        ref_mem[a[9:0]] = (o == 0) ? wdata0 : wdata1;
                    end
                end
                if (!ro) begin
                    m_owner = rx ? 1 - o : -1;
                    m_last = (o == 1); m_streak = 0;
                end else if (rx) begin
                    m_streak++;
                    if (m_streak >= MAXB) begin
                        m_owner = 1 - o; m_last = (o == 1); m_streak = 0;
                    end
                end
            end else begin
                if (req0 && req1) m_owner = m_last ? 0 : 1;
                else if (req0)    m_owner = 0;
                else if (req1)    m_owner = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] keep;
        logic        exp0;
        step(); step(); step();
        reset = 1'b1;
        // Idle after reset.
        repeat (10) step();
        chk("idle_out", {gnt1, gnt0, we_b, addr_b}, 19'h0);

        // req0 reads 0x10..0x13.
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        step();
        chk("t2_gnt0", gnt0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            addr0 = 16'h0010 + 16'(i);
            step();
            chk("t2_rvalid0", rvalid0, 1'b1);
            chk("t2_rdata", rdata, 16'h00A0 + 16'(i));
        end
        req0 = 0;
        step();

        // Fresh reset, then contested reads.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0020; addr1 = 16'h0021;
        for (int c = 0; c < 20; c++) begin
            step();
            exp0 = ((c / 8) % 2) == 0;
            chk("t3_gnt", {gnt1, gnt0}, {~exp0, exp0});
        end
        req0 = 0; req1 = 0;
        step();

        // req1 writes, req0 reads back.
        req1 = 1; we1 = 1; addr1 = 16'h0040; wdata1 = 16'hBEEF;
        step();
        chk("t4_gnt1", gnt1, 1'b1);
        step();
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 16'h0040;
        step();
        chk("t4_gnt0", gnt0, 1'b1);
        step();
        chk("t4_rvalid0", rvalid0, 1'b1);
        chk("t4_rdata", rdata, 16'hBEEF);
        req0 = 0;
        step();

        // req0 yields after three contested cycles.
        req0 = 1; we0 = 0; addr0 = 16'h0001;
        step();
        req1 = 1; we1 = 0; addr1 = 16'h0002;
        step(); step(); step();
        req0 = 0;
        step();
        chk("t5_gnt", {gnt1, gnt0}, 2'b10);
        req0 = 1;
        for (int k = 1; k < 8; k++) begin
            step();
            chk("t5_hold1", {gnt1, gnt0}, 2'b10);
        end
        step();
        chk("t5_back0", {gnt1, gnt0}, 2'b01);
        req0 = 0; req1 = 0;
        step();

        // Reset while a read response is visible and a write is on port B.
        req0 = 1; we0 = 0; addr0 = 16'h0005;
        step(); step();
        chk("t6_rv_pending", rvalid0, 1'b1);
        we0 = 1; wdata0 = 16'h7777;
        #1;
        chk("t6_we_b_pre", we_b, 1'b1);
        reset = 1'b0;
        #1;
        chk("t6_drop", {gnt0, rvalid0, we_b}, 3'b000);
        req0 = 0; we0 = 0;
        step();
        reset = 1'b1;
        step();
        chk("t6_idle", {gnt1, gnt0}, 2'b00);

`ifdef MMIO_GUARD_EN
        keep = bram[10'h300];
        req0 = 1; we0 = 1; addr0 = 16'h0300; wdata0 = 16'h1234;
        step();
        step();
        chk("mmio_io", io_violation, 1'b1);
        req0 = 0; we0 = 0;
        step();
        chk("mmio_io_end", io_violation, 1'b0);
        chk("mmio_bram", bram[10'h300], keep);
`else
        keep = 16'h0;
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            we0 = $urandom_range(0, 1);
            we1 = $urandom_range(0, 1);
            addr0 = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 1023));
            addr1 = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 1023));
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            step();
        end
        req0 = 0; req1 = 0;
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_portb_arbiter.md
Name: bram_portb_arbiter

Overview:
- Shares BRAM port B between two bus masters: requester 0 (e.g. a DMA or copy engine) and requester 1 (e.g. a display/scan reader).
- Each requester uses a req/gnt handshake. The arbiter registers ownership, muxes the owner's address, data and write-enable onto port B, and returns registered read data with a valid strobe.
- Round-robin arbitration with a bounded burst length, so neither master can starve the other.
- Sits at top level between the requesters and the port-B signals (addr_b, data_b, we_b, q_b) of the dual-port BRAM, which is clocked on ~clk.

Parameters:
- WIDTH, 16, data and address width, matching the BRAM and CPU.
- MAX_BURST, 8, maximum consecutive owned cycles while the other requester is waiting; legal range 1..255.

Ports:
- clk  input  1  system clock (50 MHz); all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req0, req1  input  1 each  request; held high for as long as transfers are wanted.
- we0, we1  input  1 each  write (1) or read (0) for the current cycle.
- addr0, addr1  input  WIDTH each  word address.
- wdata0, wdata1  input  WIDTH each  write data.
- gnt0, gnt1  output  1 each  ownership; a transfer occurs in each cycle where reqN && gntN.
- rvalid0, rvalid1  output  1 each  read data valid, one cycle after the read transfer.
- rdata  output  WIDTH  registered read data, shared; qualify with rvalidN.
- addr_b  output  WIDTH  to BRAM port B.
- data_b  output  WIDTH  to BRAM port B.
- we_b  output  1  to BRAM port B.
- q_b  input  WIDTH  from BRAM port B.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, last=1 (so requester 0 wins first), burst_cnt=0.
  - gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, we_b=0.
- States: IDLE, OWN0, OWN1. gntN is 1 exactly when state==OWNN (registered, glitch-free).
- Port-B mux (combinational):
  - In OWNN: addr_b=addrN, data_b=wdataN, we_b=weN&reqN.
  - In IDLE: addr_b=0, data_b=0, we_b=0.
- IDLE transitions:
  - Neither request: stay in IDLE.
  - Only reqN: go to OWNN.
  - Both: go to OWN of (1-last).
  - Arbitration latency is one cycle from req rising to gnt.
- OWNN transitions, evaluated at each posedge with O = the other requester:
  - reqN==0: go to OWNO if reqO, else IDLE. No transfer this cycle.
  - reqN==1 and reqO==1 and burst_cnt==MAX_BURST-1: go to OWNO. This cycle's transfer still completes.
  - Otherwise stay in OWNN; burst_cnt increments, saturating at MAX_BURST-1.
  - Whenever ownership changes: burst_cnt=0 and last=N.
- Burst counting: burst_cnt only advances while the other requester is waiting. An unopposed owner keeps ownership indefinitely.
- Reads:
  - A read transfer in cycle t presents addr_b at posedge t; the BRAM samples on negedge t.
  - At posedge t+1: rdata<=q_b and rvalidN<=1 for exactly one cycle per read transfer.
  - Back-to-back reads give continuous rvalid. rvalid is independent of later grant loss.
- Writes: take effect at the BRAM negedge of the transfer cycle; no response strobe.
- Simultaneous requests from IDLE: strict alternation via last.
- A requester dropping req in the same cycle its grant would expire: go to OWNO if reqO, else IDLE.
- Reset mid-operation: an in-flight rvalid is cancelled, and we_b drops immediately (combinational from state).

Optional Feature:
- Macro: MMIO_GUARD_EN.
- Defined:
  - Any transfer with addr[9]&addr[8]==1 is blocked from BRAM: we_b forced 0.
  - The read returns rdata=0 with rvalid still asserted.
  - Output io_violation (1-bit, reset 0) pulses for one cycle after the blocked access, reserving the I/O window for port A memory-mapped I/O.
- Undefined: addresses pass through unmodified and the io_violation port is absent.

Test Plan:
1. Reset release, no requests: gnt0=gnt1=0, we_b=0, addr_b=0 for 10 cycles.
2. req0 alone, reads of addr 0x0010..0x0013 (BRAM preloaded 0xA0..0xA3):
   - gnt0 rises the next cycle.
   - rvalid0 is high for 4 consecutive cycles with rdata 0xA0,0xA1,0xA2,0xA3.
3. req0 and req1 asserted together from IDLE, both held high with MAX_BURST=8:
   - gnt0 for 8 cycles, then gnt1 for 8, then gnt0 again.
   - gnt0 and gnt1 are never high together.
4. req1 write of 0xBEEF to 0x0040, then req0 read of 0x0040: req0 read returns rdata=0xBEEF with rvalid0.
5. req0 owning with req1 waiting, req0 drops at burst count 3: gnt1 on the next cycle, burst_cnt=0, last=0.
6. Reset asserted mid-burst with rvalid0 pending: gnt0, rvalid0 and we_b drop to 0 immediately; IDLE after release. With MMIO_GUARD_EN, a req0 write to 0x0300 leaves BRAM unchanged and io_violation=1 for one cycle.
